display_src_ctrl: RTL and testbench
===================================

Name: display_src_ctrl

Overview:
- Sequencer that decides what the 6-digit scanned 7-segment display shows.
- Selects between time-of-day, alarm setting, a serially received value (timed overlay) and the alarm-ringing indication.
- Produces registered hour/minute/second fields plus a per-digit blank mask and a dash flag, which feed the display scanner.
- Also generates the edit-field blink.

Parameters:
- BLINK_HALF, 25000000, clk cycles per blink half-period.
- OVERLAY_SEC, 3, seconds an RX overlay stays on screen (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tick_1hz  in  1  one-clk pulse per second
- mode_btn  in  1  debounced one-clk pulse; toggles time/alarm view
- edit_sel  in  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds
- tod_h, tod_m, tod_s  in  7 each  time of day
- alm_h, alm_m  in  7 each  alarm setting
- rx_valid  in  1  one-clk pulse; rx_h/rx_m/rx_s valid
- rx_h, rx_m, rx_s  in  7 each  serially received value
- alarm_ring  in  1  level; alarm active
- stop  in  1  one-clk pulse; user silences alarm
- disp_h, disp_m, disp_s  out  7 each  fields to scanner
- blank  out  6  1 = digit dark; bit0 seconds-ones … bit5 hours-tens
- dash  out  1  1 = all digits show '-'
- mode  out  2  current state code

Behaviour:
- All outputs are registered. Outputs reflect the inputs/state of the previous cycle (1-cycle latency).
- Reset values: all outputs 0, state TIME, ret_state TIME, blink phase 0, blink counter 0, overlay counter 0, rx latch 0.
- States and codes: TIME=0, ALARM=1, RX=2, RING=3.
- Transition priority per cycle: RING entry > RX entry/reload > mode_btn.
- TIME:
  - Shows tod_h/tod_m/tod_s.
  - mode_btn -> ALARM.
  - rx_valid -> RX: latch rx fields, load overlay counter with OVERLAY_SEC, set ret_state=TIME.
- ALARM:
  - Shows alm_h, alm_m, disp_s=0; blank[1:0]=2'b11.
  - mode_btn -> TIME.
  - rx_valid -> RX with ret_state=ALARM.
- RX:
  - Shows the latched rx fields. mode_btn is ignored.
  - Each tick_1hz decrements the overlay counter. The cycle the counter reaches 0, go to ret_state.
  - rx_valid in RX re-latches the fields and reloads the counter. A reload wins over a simultaneous tick.
- RING:
  - Entered on the rising edge of alarm_ring from any state; the RX overlay is abandoned.
  - dash = blink phase. When dash=0, shows time of day.
  - Exits to TIME on a stop pulse or when alarm_ring falls, whichever comes first. The edge detector is updated regardless of state, so a level still high after stop does not re-enter RING.
- Blink:
  - The counter counts 0..BLINK_HALF-1; on wrap, the phase toggles.
  - Any change of edit_sel clears the counter and phase, so the selected field is visible immediately.
  - In TIME and ALARM, when edit_sel!=0 and phase=1, the selected field's two blank bits are set (hours bits 5:4, minutes 3:2, seconds 1:0).
  - edit_sel=3 in ALARM: the seconds bits are already blank.
  - No edit blink in RX or RING.
- Range check, applied to the displayed source:
  - Hours > 23 or minutes/seconds > 59 -> that field outputs 0 and its two blank bits are forced to 1.
  - Example: 60 is invalid -> blank, matching the existing clear-on-60 convention.
- rst mid-operation (any state, any counter value): next-cycle outputs equal the reset values; no residual overlay or RING.

Decomposition:
- Shared package display_pkg:
  - state enum and codes
  - edit_sel field codes
  - blank mask constants HR_MASK=6'b110000, MIN_MASK=6'b001100, SEC_MASK=6'b000011
  - limits MAX_H=23, MAX_MS=59
- One sub-module, blink_gen: BLINK_HALF counter, restart input, phase output. Reusable by the alarm-set logic.

Test Plan:
- Reset, tod=12:34:56, no events -> disp 12/34/56, blank=0, dash=0, mode=0 one cycle after rst falls.
- mode_btn pulse with alm=07:30 -> mode=1, disp 7/30/0, blank=6'b000011. Second pulse -> mode=0.
- rx_valid with 01:02:03 in ALARM, BLINK_HALF=4, OVERLAY_SEC=3:
  - mode=2, shows 1/2/3.
  - After 3 ticks -> mode=1.
  - A second rx_valid after 2 ticks extends the overlay to 5 ticks total.
  - tick and rx_valid in the same cycle -> counter reloaded to 3.
- edit_sel=2 in TIME with BLINK_HALF=4 -> blank toggles 0 / 6'b001100 every 4 cycles. Changing edit_sel to 1 mid-phase -> blank=0 next cycle, then 6'b110000 after 4 cycles.
- alarm_ring rises during RX:
  - mode=3, dash toggles every BLINK_HALF.
  - stop pulse -> mode=0, dash=0, with alarm_ring still high and no re-entry.
  - Separately, alarm_ring falling -> TIME.
- tod_s=60, tod_h=24 -> disp_s=0, disp_h=0, blank=6'b110011. rst asserted in RX with counter=2 -> mode=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared codes, masks and limits for the display source sequencer
package display_pkg;

  localparam logic [1:0] ST_TIME  = 2'd0;
  localparam logic [1:0] ST_ALARM = 2'd1;
  localparam logic [1:0] ST_RX    = 2'd2;
  localparam logic [1:0] ST_RING  = 2'd3;

  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_HR   = 2'd1;
  localparam logic [1:0] EDIT_MIN  = 2'd2;
  localparam logic [1:0] EDIT_SEC  = 2'd3;

  localparam logic [5:0] HR_MASK  = 6'b110000;
  localparam logic [5:0] MIN_MASK = 6'b001100;
  localparam logic [5:0] SEC_MASK = 6'b000011;

  localparam logic [6:0] MAX_H  = 7'd23;
  localparam logic [6:0] MAX_MS = 7'd59;

  // Blank bits belonging to the field under edit; none when not editing.
  function automatic logic [5:0] edit_mask(input logic [1:0] sel);
    case (sel)
      EDIT_HR:  edit_mask = HR_MASK;
      EDIT_MIN: edit_mask = MIN_MASK;
      EDIT_SEC: edit_mask = SEC_MASK;
      default:  edit_mask = 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - half-period counter with phase toggle and synchronous restart
module blink_gen #(
  parameter int BLINK_HALF = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase,
  output logic phase_next
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // phase_next lets a consumer register outputs against the same edge's phase.
  always_comb begin
    cnt_next   = cnt + CW'(1);
    phase_next = phase;
    if (restart) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (cnt == LAST) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/display_src_ctrl.sv
// rtl/display_src_ctrl.sv - selects time, alarm, rx overlay or ring view for the scanner
module display_src_ctrl
  import display_pkg::*;
#(
  parameter int BLINK_HALF  = 25000000,
  parameter int OVERLAY_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic [1:0] edit_sel,
  input  logic [6:0] tod_h,
  input  logic [6:0] tod_m,
  input  logic [6:0] tod_s,
  input  logic [6:0] alm_h,
  input  logic [6:0] alm_m,
  input  logic       rx_valid,
  input  logic [6:0] rx_h,
  input  logic [6:0] rx_m,
  input  logic [6:0] rx_s,
  input  logic       alarm_ring,
  input  logic       stop,
  output logic [6:0] disp_h,
  output logic [6:0] disp_m,
  output logic [6:0] disp_s,
  output logic [5:0] blank,
  output logic       dash,
  output logic [1:0] mode
);

  localparam logic [3:0] OVL_LOAD = 4'(OVERLAY_SEC);

  logic [1:0] state, state_d;
  logic [1:0] ret_state, ret_d;
  logic [3:0] ovl_cnt, ovl_d;
  logic [6:0] rxh_q, rxm_q, rxs_q;
  logic [6:0] rxh_d, rxm_d, rxs_d;
  logic       ring_q;
  logic [1:0] edit_q;
  logic       ring_rise;
  logic       blink_restart;
  logic       phase, phase_d;

  logic [6:0] src_h, src_m, src_s;
  logic [6:0] out_h, out_m, out_s;
  logic [5:0] out_blank;
  logic       out_dash;

  assign ring_rise     = alarm_ring & ~ring_q;
  assign blink_restart = (edit_sel != edit_q);

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk        (clk),
    .rst        (rst),
    .restart    (blink_restart),
    .phase      (phase),
    .phase_next (phase_d)
  );

  always_comb begin
    state_d = state;
    ret_d   = ret_state;
    ovl_d   = ovl_cnt;
    rxh_d   = rxh_q;
    rxm_d   = rxm_q;
    rxs_d   = rxs_q;
    if (ring_rise) begin
      state_d = ST_RING;
      ovl_d   = 4'd0;
    end else begin
      case (state)
        ST_TIME, ST_ALARM: begin
          if (rx_valid) begin
            state_d = ST_RX;
            ret_d   = state;
            ovl_d   = OVL_LOAD;
            rxh_d   = rx_h;
            rxm_d   = rx_m;
            rxs_d   = rx_s;
          end else if (mode_btn) begin
            state_d = (state == ST_TIME) ? ST_ALARM : ST_TIME;
          end
        end
        ST_RX: begin
          // A reload beats a coincident tick so the new value gets its full time.
          if (rx_valid) begin
            ovl_d = OVL_LOAD;
            rxh_d = rx_h;
            rxm_d = rx_m;
            rxs_d = rx_s;
          end else if (tick_1hz) begin
            ovl_d = ovl_cnt - 4'd1;
            if (ovl_cnt <= 4'd1) begin
              ovl_d   = 4'd0;
              state_d = ret_state;
            end
          end
        end
        default: begin
          if (stop || !alarm_ring) state_d = ST_TIME;
        end
      endcase
    end
  end

  always_comb begin
    src_h     = tod_h;
    src_m     = tod_m;
    src_s     = tod_s;
    out_blank = 6'b000000;
    out_dash  = 1'b0;
    case (state_d)
      ST_ALARM: begin
        src_h     = alm_h;
        src_m     = alm_m;
        src_s     = 7'd0;
        out_blank = SEC_MASK;
      end
      ST_RX: begin
        src_h = rxh_d;
        src_m = rxm_d;
        src_s = rxs_d;
      end
      ST_RING: out_dash = phase_d;
      default: ;
    endcase

    out_h = src_h;
    out_m = src_m;
    out_s = src_s;
    if (src_h > MAX_H) begin
      out_h     = 7'd0;
      out_blank = out_blank | HR_MASK;
    end
    if (src_m > MAX_MS) begin
      out_m     = 7'd0;
      out_blank = out_blank | MIN_MASK;
    end
    if (src_s > MAX_MS) begin
      out_s     = 7'd0;
      out_blank = out_blank | SEC_MASK;
    end

    if ((state_d == ST_TIME || state_d == ST_ALARM) && phase_d)
      out_blank = out_blank | edit_mask(edit_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_TIME;
      ret_state <= ST_TIME;
      ovl_cnt   <= 4'd0;
      rxh_q     <= 7'd0;
      rxm_q     <= 7'd0;
      rxs_q     <= 7'd0;
      ring_q    <= 1'b0;
      edit_q    <= EDIT_NONE;
      disp_h    <= 7'd0;
      disp_m    <= 7'd0;
      disp_s    <= 7'd0;
      blank     <= 6'b000000;
      dash      <= 1'b0;
      mode      <= ST_TIME;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
      ovl_cnt   <= ovl_d;
      rxh_q     <= rxh_d;
      rxm_q     <= rxm_d;
      rxs_q     <= rxs_d;
      ring_q    <= alarm_ring;
      edit_q    <= edit_sel;
      disp_h    <= out_h;
      disp_m    <= out_m;
      disp_s    <= out_s;
      blank     <= out_blank;
      dash      <= out_dash;
      mode      <= state_d;
    end
  end

endmodule

// File: tb/tb_display_src_ctrl.sv
// tb/tb_display_src_ctrl.sv - scoreboard bench for display_src_ctrl against a view-level model
module tb_display_src_ctrl;

  localparam int BH = 4;
  localparam int OS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, mode_btn = 1'b0, rx_valid = 1'b0, alarm_ring = 1'b0, stop = 1'b0;
  logic [1:0] edit_sel = 2'd0;
  logic [6:0] tod_h = 7'd0, tod_m = 7'd0, tod_s = 7'd0, alm_h = 7'd0, alm_m = 7'd0;
  logic [6:0] rx_h = 7'd0, rx_m = 7'd0, rx_s = 7'd0;
  logic [6:0] disp_h, disp_m, disp_s;
  logic [5:0] blank;
  logic       dash;
  logic [1:0] mode;

  always #5 clk = ~clk;

  display_src_ctrl #(.BLINK_HALF(BH), .OVERLAY_SEC(OS)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .edit_sel(edit_sel),
    .tod_h(tod_h), .tod_m(tod_m), .tod_s(tod_s), .alm_h(alm_h), .alm_m(alm_m),
    .rx_valid(rx_valid), .rx_h(rx_h), .rx_m(rx_m), .rx_s(rx_s),
    .alarm_ring(alarm_ring), .stop(stop),
    .disp_h(disp_h), .disp_m(disp_m), .disp_s(disp_s), .blank(blank), .dash(dash), .mode(mode)
  );

  int total = 0;
  int bad = 0;
  logic [29:0] expq[$];

  // view: 0 time, 1 alarm, 2 rx overlay, 3 ringing
  int m_view = 0, m_ret = 0, m_rem = 0, m_rh = 0, m_rm = 0, m_rs = 0;
  int m_since = 0, m_edit_prev = 0;
  bit m_ring_prev = 0;

  function automatic logic [29:0] pack(int h, int m, int s, logic [5:0] bl, logic d, int md);
    logic [6:0] h7, m7, s7;
    logic [1:0] md2;
    h7 = 7'(h); m7 = 7'(m); s7 = 7'(s); md2 = 2'(md);
    return {h7, m7, s7, bl, d, md2};
  endfunction

  function automatic logic [29:0] actual();
    return {disp_h, disp_m, disp_s, blank, dash, mode};
  endfunction

  task automatic model_step();
    int h, m, s, phase;
    logic [5:0] bl;
    logic d;
    bit rise;
    if (rst) begin
      m_view = 0; m_ret = 0; m_rem = 0; m_rh = 0; m_rm = 0; m_rs = 0;
      m_since = 0; m_edit_prev = 0; m_ring_prev = 0;
      expq.push_back(30'd0);
      return;
    end
    rise = alarm_ring && !m_ring_prev;
    m_ring_prev = alarm_ring;
    if (int'(edit_sel) != m_edit_prev) m_since = 0;
    else m_since++;
    m_edit_prev = int'(edit_sel);
    phase = (m_since / BH) % 2;

    if (rise) begin
      m_view = 3;
      m_rem = 0;
    end else if (m_view <= 1) begin
      if (rx_valid) begin
        m_ret = m_view; m_view = 2; m_rem = OS;
        m_rh = rx_h; m_rm = rx_m; m_rs = rx_s;
      end else if (mode_btn) m_view = 1 - m_view;
    end else if (m_view == 2) begin
      if (rx_valid) begin
        m_rem = OS; m_rh = rx_h; m_rm = rx_m; m_rs = rx_s;
      end else if (tick_1hz) begin
        m_rem--;
        if (m_rem == 0) m_view = m_ret;
      end
    end else if (stop || !alarm_ring) m_view = 0;

    bl = 6'd0;
    d = 1'b0;
    h = tod_h; m = tod_m; s = tod_s;
    if (m_view == 1) begin h = alm_h; m = alm_m; s = 0; bl = 6'b000011; end
    if (m_view == 2) begin h = m_rh; m = m_rm; s = m_rs; end
    if (m_view == 3) d = (phase == 1);
    if (h > 23) begin h = 0; bl |= 6'b110000; end
    if (m > 59) begin m = 0; bl |= 6'b001100; end
    if (s > 59) begin s = 0; bl |= 6'b000011; end
    if (m_view <= 1 && edit_sel != 0 && phase == 1) bl |= 6'b000011 << (2 * (3 - int'(edit_sel)));
    expq.push_back(pack(h, m, s, bl, d, m_view));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    tick_1hz = 1'b0; mode_btn = 1'b0; rx_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(string name, logic [29:0] want);
    total++;
    if (actual() !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, actual(), want);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [29:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got h=%0d m=%0d s=%0d blank=%b dash=%b mode=%0d want h=%0d m=%0d s=%0d blank=%b dash=%b mode=%0d",
                 $time, disp_h, disp_m, disp_s, blank, dash, mode,
                 e[29:23], e[22:16], e[15:9], e[8:3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    tod_h = 7'd12; tod_m = 7'd34; tod_s = 7'd56;
    alm_h = 7'd7; alm_m = 7'd30;
    idle(2);
    rst = 1'b0;
    cyc();
    chk("reset_release_time", pack(12, 34, 56, 6'd0, 1'b0, 0));

    mode_btn = 1'b1; cyc();
    chk("alarm_view", pack(7, 30, 0, 6'b000011, 1'b0, 1));
    mode_btn = 1'b1; cyc();
    chk("back_to_time", pack(12, 34, 56, 6'd0, 1'b0, 0));

    mode_btn = 1'b1; cyc();
    rx_h = 7'd1; rx_m = 7'd2; rx_s = 7'd3; rx_valid = 1'b1; cyc();
    chk("rx_overlay", pack(1, 2, 3, 6'd0, 1'b0, 2));
    for (int i = 0; i < 3; i++) begin idle(2); tick_1hz = 1'b1; cyc(); end
    chk("overlay_expired", pack(7, 30, 0, 6'b000011, 1'b0, 1));

    rx_valid = 1'b1; cyc();
    for (int i = 0; i < 2; i++) begin idle(1); tick_1hz = 1'b1; cyc(); end
    rx_valid = 1'b1; tick_1hz = 1'b1; cyc();
    for (int i = 0; i < 2; i++) begin idle(1); tick_1hz = 1'b1; cyc(); end
    chk("reload_beats_tick", pack(1, 2, 3, 6'd0, 1'b0, 2));
    idle(1); tick_1hz = 1'b1; cyc();
    chk("reload_expired", pack(7, 30, 0, 6'b000011, 1'b0, 1));

    mode_btn = 1'b1; cyc();
    edit_sel = 2'd2; idle(10);
    edit_sel = 2'd1; cyc();
    chk("edit_restart_visible", pack(12, 34, 56, 6'd0, 1'b0, 0));
    idle(6);
    edit_sel = 2'd0; cyc();

    rx_valid = 1'b1; cyc();
    alarm_ring = 1'b1; cyc();
    chk("ring_entry", pack(12, 34, 56, 6'd0, 1'b0, 3));
    idle(10);
    stop = 1'b1; cyc();
    chk("stop_exits", pack(12, 34, 56, 6'd0, 1'b0, 0));
    idle(5);
    alarm_ring = 1'b0; idle(2);
    alarm_ring = 1'b1; idle(6);
    alarm_ring = 1'b0; cyc();
    chk("ring_fall_exits", pack(12, 34, 56, 6'd0, 1'b0, 0));

    tod_h = 7'd24; tod_m = 7'd10; tod_s = 7'd60; cyc();
    chk("range_check", pack(0, 10, 0, 6'b110011, 1'b0, 0));

    rx_valid = 1'b1; cyc();
    tick_1hz = 1'b1; cyc();
    rst = 1'b1; cyc();
    chk("reset_in_rx", 30'd0);
    rst = 1'b0; idle(2);

    for (int i = 0; i < 3000; i++) begin
      tick_1hz = ($urandom_range(0, 7) == 0);
      mode_btn = ($urandom_range(0, 15) == 0);
      rx_valid = ($urandom_range(0, 39) == 0);
      stop = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 59) == 0) alarm_ring = ~alarm_ring;
      if ($urandom_range(0, 49) == 0) edit_sel = 2'($urandom_range(0, 3));
      if (tick_1hz) begin
        tod_h = 7'($urandom_range(0, 26)); tod_m = 7'($urandom_range(0, 63)); tod_s = 7'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 99) == 0) begin
        alm_h = 7'($urandom_range(0, 26)); alm_m = 7'($urandom_range(0, 63));
      end
      rx_h = 7'($urandom_range(0, 30)); rx_m = 7'($urandom_range(0, 70)); rx_s = 7'($urandom_range(0, 70));
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    idle(3);
    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
